// File: rtl/psd_sqrt_pkg.sv
// Shared widths for the sequential integer square-root unit.
package psd_sqrt_pkg;

  localparam int unsigned XW    = 32;
  localparam int unsigned RW    = 16;
  localparam int unsigned NITER = 16;
  localparam int unsigned REMW  = RW + 2;
  localparam int unsigned CNTW  = 5;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NITER);

  typedef logic [XW-1:0]   opnd_t;
  typedef logic [RW-1:0]   root_t;
  typedef logic [REMW-1:0] rem_t;
  typedef logic [CNTW-1:0] cnt_t;

endpackage

// File: rtl/psd_sqrt_step.sv
// One restoring square-root iteration: brings down two operand bits, tries to subtract
// {root, 01} and shifts the resulting root bit in.
module psd_sqrt_step
  import psd_sqrt_pkg::*;
(
  input  logic [RW-1:0]   rem_low,
  input  logic [1:0]      opnd_top,
  input  logic [RW-1:0]   root,
  output logic [REMW-1:0] rem_next,
  output logic [RW-1:0]   root_next
);

  logic [REMW-1:0] r;
  logic [REMW-1:0] t;

  // Before any iteration the remainder is below 2^16, so its upper bits can be dropped.
  assign r = {rem_low, opnd_top};
  assign t = {root, 2'b01};

  always_comb begin
    rem_next  = r;
    root_next = {root[RW-2:0], 1'b0};
    if (r >= t) begin
      rem_next  = r - t;
      root_next = {root[RW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/psd_sqrt.sv
// Sequential floor(sqrt(xin)): start launches 16 iterations, stop copies the root to sqrt.
module psd_sqrt
  import psd_sqrt_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [XW-1:0] xin,
  output logic [RW-1:0] sqrt
);

  opnd_t opnd_q, opnd_d;
  rem_t  rem_q, rem_d;
  root_t root_q, root_d;
  cnt_t  cnt_q, cnt_d;
  logic  busy_q, busy_d;
  root_t sqrt_q, sqrt_d;

  rem_t  step_rem;
  root_t step_root;

  psd_sqrt_step u_step (
    .rem_low   (rem_q[RW-1:0]),
    .opnd_top  (opnd_q[XW-1:XW-2]),
    .root      (root_q),
    .rem_next  (step_rem),
    .root_next (step_root)
  );

  always_comb begin
    opnd_d = opnd_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    sqrt_d = sqrt_q;

    // Output takes the pre-edge root, so stop alongside start reports the old result.
    if (stop) begin
      sqrt_d = root_q;
    end

    if (start) begin
      opnd_d = xin;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = step_rem;
      root_d = step_root;
      opnd_d = {opnd_q[XW-3:0], 2'b00};
      cnt_d  = cnt_q + cnt_t'(1);
      if (cnt_d == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opnd_q <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      sqrt_q <= '0;
    end else begin
      opnd_q <= opnd_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      sqrt_q <= sqrt_d;
    end
  end

  assign sqrt = sqrt_q;

endmodule

// File: tb/tb_psd_sqrt.sv
// Directed and random checks of psd_sqrt against an integer square-root reference.
module tb_psd_sqrt;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [31:0] xin   = '0;
  logic [15:0] sqrt;

  int total = 0;
  int bad   = 0;

  psd_sqrt dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .xin   (xin),
    .sqrt  (sqrt)
  );

  always #5 clock = ~clock;

  // Largest r with r*r <= x, by binary search in 64-bit arithmetic.
  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint lo, hi, mid, xx;
    xx = longint'(x);
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= xx) lo = mid;
      else hi = mid - 1;
    end
    return 16'(lo);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full start / 16 iterations / stop sequence; optionally scrambles xin after start.
  task automatic run(input logic [31:0] x, input bit scramble);
    start = 1'b1;
    xin   = x;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (scramble) xin = $urandom;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [31:0] xs   [15];
  logic [15:0] exps [15];
  logic [31:0] x, x2;

  initial begin
    xs[0]  = 32'd0;          exps[0]  = 16'd0;
    xs[1]  = 32'd1;          exps[1]  = 16'd1;
    xs[2]  = 32'd2;          exps[2]  = 16'd1;
    xs[3]  = 32'd4;          exps[3]  = 16'd2;
    xs[4]  = 32'd65536;      exps[4]  = 16'd256;
    xs[5]  = 32'h8000_0000;  exps[5]  = 16'd46340;
    xs[6]  = 32'd65552;      exps[6]  = 16'd256;
    xs[7]  = 32'h8000_001F;  exps[7]  = 16'd46340;
    xs[8]  = 32'd3;          exps[8]  = 16'd1;
    xs[9]  = 32'd6;          exps[9]  = 16'd2;
    xs[10] = 32'hFFFF_FFFF;  exps[10] = 16'd65535;
    xs[11] = 32'hFFFE_0001;  exps[11] = 16'd65535;
    xs[12] = 32'hFFFE_0000;  exps[12] = 16'd65534;
    xs[13] = 32'd144;        exps[13] = 16'd12;
    xs[14] = 32'd100;        exps[14] = 16'd10;

    #12;
    check("reset_sqrt", sqrt, 16'd0);
    reset = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_no_start", sqrt, 16'd0);

    for (int i = 0; i < 15; i++) begin
      run(xs[i], 1'b0);
      check($sformatf("fixed_%0d", i), sqrt, exps[i]);
    end

    for (int i = 0; i < 32; i++) begin
      x = 32'd1 << i;
      run(x, 1'b0);
      check($sformatf("pow2_%0d", i), sqrt, isqrt(x));
      x = x + 32'(i);
      run(x, 1'b0);
      check($sformatf("pow2_plus_%0d", i), sqrt, isqrt(x));
    end

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      run(x, i[0]);
      check($sformatf("rand_%0d", i), sqrt, isqrt(x));
    end

    // sqrt holds while xin wanders and nothing is pulsed
    x = $urandom;
    run(x, 1'b0);
    for (int i = 0; i < 5; i++) begin
      xin = $urandom;
      repeat (4) tick();
      check($sformatf("hold_%0d", i), sqrt, isqrt(x));
    end

    // Restart at the edge that would be iteration 8
    x = $urandom;
    start = 1'b1;
    xin   = x;
    tick();
    start = 1'b0;
    repeat (7) tick();
    run(32'd100, 1'b0);
    check("restart_mid", sqrt, 16'd10);

    // Stop after 8 iterations yields the root of the top 16 operand bits
    x = $urandom;
    start = 1'b1;
    xin   = x;
    tick();
    start = 1'b0;
    repeat (8) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("partial_root", sqrt, isqrt(x >> 16));
    repeat (7) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("partial_then_full", sqrt, isqrt(x));

    // start and stop on the same edge: old root out, new computation in
    x  = $urandom;
    x2 = $urandom;
    start = 1'b1;
    xin   = x;
    tick();
    start = 1'b0;
    repeat (16) tick();
    start = 1'b1;
    stop  = 1'b1;
    xin   = x2;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_old", sqrt, isqrt(x));
    repeat (16) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("start_stop_new", sqrt, isqrt(x2));

    // Asynchronous reset between edges mid-computation
    run(32'hFFFF_FFFF, 1'b0);
    check("pre_reset", sqrt, 16'd65535);
    start = 1'b1;
    xin   = $urandom;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", sqrt, 16'd0);
    #1;
    reset = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_after_reset", sqrt, 16'd0);
    run(32'd144, 1'b0);
    check("after_reset_144", sqrt, 16'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
